// File: rtl/isp_stat_ae.sv
// isp_stat_ae: AE statistics on the post-dgain Bayer stream.
// Window count/sum plus a per-channel histogram RAM, read by the host in IDLE.
// Ports: pclk/rst_n; stat_en and rect_* are sampled at frame start;
//   in_href/in_vsync/in_raw carry the pixel stream; stat_* are the frame
//   results; hist_rd_addr/hist_rd_data form the host histogram read port.
module isp_stat_ae #(
  parameter int BITS          = 8,
  parameter int BAYER         = 0,
  parameter int HIST_BITS     = 8,
  parameter int STAT_OUT_BITS = 32
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     stat_en,
  input  logic [15:0]              rect_x,
  input  logic [15:0]              rect_y,
  input  logic [15:0]              rect_w,
  input  logic [15:0]              rect_h,
  input  logic                     in_href,
  input  logic                     in_vsync,
  input  logic [BITS-1:0]          in_raw,
  output logic                     stat_done,
  output logic [STAT_OUT_BITS-1:0] stat_pix_cnt,
  output logic [STAT_OUT_BITS-1:0] stat_sum,
  output logic                     stat_hist_err,
  input  logic [HIST_BITS+1:0]     hist_rd_addr,
  output logic [STAT_OUT_BITS-1:0] hist_rd_data
);

  localparam int SW    = STAT_OUT_BITS;
  localparam int AW    = HIST_BITS + 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [SW-1:0] SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_DONE
  } state_t;

  state_t          state_q;
  logic            vs_q, href_q;
  logic [15:0]     x_q, y_q;
  logic [15:0]     rx_q, ry_q, rw_q, rh_q;
  logic [SW-1:0]   cnt_q, sum_q;
  logic            err_q, flush_q;
  logic [AW-1:0]   clr_q;
  logic            v1_q;
  logic [AW-1:0]   a1_q;
  logic [SW-1:0]   rd_q;
  logic            wv_q;
  logic [AW-1:0]   wa_q;
  logic [SW-1:0]   wd_q;
  logic [SW-1:0]   mem [DEPTH];

  logic            fs, fe, hfall, active, in_win, hit;
  logic [16:0]     x17, y17, xe, ye;
  logic [1:0]      ch;
  logic [AW-1:0]   haddr;
  logic [SW:0]     sum_x;
  logic [SW-1:0]   sum_d, cnt_d, old, bin_d;

  // Edges are the live input against its registered copy.
  assign fs     = in_vsync & ~vs_q;
  assign fe     = ~in_vsync & vs_q;
  assign hfall  = href_q & ~in_href;
  assign active = (state_q == S_CLEAR) || (state_q == S_ACCUM);

  // 17-bit bounds so x+w never wraps into the window.
  assign x17    = {1'b0, x_q};
  assign y17    = {1'b0, y_q};
  assign xe     = {1'b0, rx_q} + {1'b0, rw_q};
  assign ye     = {1'b0, ry_q} + {1'b0, rh_q};
  assign in_win = (x17 >= {1'b0, rx_q}) && (x17 < xe) &&
                  (y17 >= {1'b0, ry_q}) && (y17 < ye);
  assign hit    = active && in_href && in_win;

  assign ch     = {y_q[0], x_q[0]} ^ 2'(BAYER);
  assign haddr  = {ch, in_raw[BITS-1 -: HIST_BITS]};

  assign sum_x  = {1'b0, sum_q} + (SW+1)'(in_raw);
  assign sum_d  = sum_x[SW] ? SAT : sum_x[SW-1:0];
  assign cnt_d  = (cnt_q == SAT) ? cnt_q : cnt_q + SW'(1);

  // The RAM read in stage 1 misses a write to the same bin landing on
  // that same edge; take the just-written value instead.
  assign old    = (wv_q && (wa_q == a1_q)) ? wd_q : rd_q;
  assign bin_d  = (old == SAT) ? old : old + SW'(1);

  always_ff @(posedge pclk) begin
    if (state_q == S_CLEAR)
      mem[clr_q] <= '0;
    else if (v1_q)
      mem[a1_q] <= bin_d;
    rd_q <= mem[haddr];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vs_q          <= 1'b1;
      href_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      rw_q          <= '0;
      rh_q          <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      err_q         <= 1'b0;
      flush_q       <= 1'b0;
      clr_q         <= '0;
      v1_q          <= 1'b0;
      a1_q          <= '0;
      wv_q          <= 1'b0;
      wa_q          <= '0;
      wd_q          <= '0;
      stat_done     <= 1'b0;
      stat_pix_cnt  <= '0;
      stat_sum      <= '0;
      stat_hist_err <= 1'b0;
      hist_rd_data  <= '0;
    end else begin
      vs_q      <= in_vsync;
      href_q    <= in_href;
      stat_done <= 1'b0;
      v1_q      <= hit && (state_q == S_ACCUM);
      a1_q      <= haddr;
      wv_q      <= v1_q;
      wa_q      <= a1_q;
      wd_q      <= bin_d;
      hist_rd_data <= (state_q == S_IDLE) ? mem[hist_rd_addr] : '0;

      if (active) begin
        if (hfall) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else if (in_href) begin
          x_q <= x_q + 16'd1;
        end
        if (hit) begin
          cnt_q <= cnt_d;
          sum_q <= sum_d;
        end
        if (hit && (state_q == S_CLEAR))
          err_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (fs && stat_en) begin
            state_q <= S_CLEAR;
            rx_q    <= rect_x;
            ry_q    <= rect_y;
            rw_q    <= rect_w;
            rh_q    <= rect_h;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            clr_q   <= '0;
          end
        end
        S_CLEAR: begin
          if (fe) begin
            state_q <= S_FLUSH;
            flush_q <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            clr_q <= clr_q + AW'(1);
            if (&clr_q)
              state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (fe) begin
            state_q <= S_FLUSH;
            flush_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q)
            state_q <= S_DONE;
        end
        S_DONE: begin
          stat_pix_cnt  <= cnt_q;
          stat_sum      <= sum_q;
          stat_hist_err <= err_q;
          stat_done     <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_stat_ae.sv
// tb_isp_stat_ae: directed bench for isp_stat_ae.
// Frames are driven by hand; results and bins are compared to fixed values.
module tb_isp_stat_ae;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stat_en = 1'b1;
  logic [15:0] rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
  logic        in_href = 1'b0, in_vsync = 1'b0;
  logic [7:0]  in_raw = '0;
  logic        stat_done, stat_hist_err;
  logic [31:0] stat_pix_cnt, stat_sum, hist_rd_data;
  logic [9:0]  hist_rd_addr = '0;

  int cmp = 0;
  int bad = 0;
  int done_cnt = 0;
  bit ramp = 1'b0;
  logic [7:0] pconst = 8'h40;

  isp_stat_ae #(
    .BITS(8), .BAYER(0), .HIST_BITS(8), .STAT_OUT_BITS(32)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .stat_en(stat_en),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
    .stat_done(stat_done), .stat_pix_cnt(stat_pix_cnt),
    .stat_sum(stat_sum), .stat_hist_err(stat_hist_err),
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk)
    if (stat_done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic lines(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        in_href = 1'b1;
        in_raw  = ramp ? 8'(x) : pconst;
        tick;
      end
      in_href = 1'b0;
      in_raw  = '0;
      repeat (4) tick;
    end
  endtask

  // Drop vsync and return the cycle stat_done is seen high, -1 if never.
  task automatic end_frame(output int lat);
    in_vsync = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (stat_done === 1'b1 && lat < 0) lat = k;
    end
  endtask

  task automatic run_frame(input int w, input int h, input int pre,
                           output int lat);
    in_vsync = 1'b1;
    repeat (pre) tick;
    lines(w, h);
    end_frame(lat);
  endtask

  task automatic hrd(input logic [9:0] a, output logic [31:0] d);
    hist_rd_addr = a;
    tick;
    d = hist_rd_data;
  endtask

  task automatic set_rect(input int x, input int y, input int w, input int h);
    rect_x = 16'(x);
    rect_y = 16'(y);
    rect_w = 16'(w);
    rect_h = 16'(h);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    cmp++;
    if (stat_pix_cnt !== 32'd0 || stat_sum !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt_sum: got %0d/%0d want 0/0",
               stat_pix_cnt, stat_sum);
    end
    cmp++;
    if (stat_done !== 1'b0 || stat_hist_err !== 1'b0 ||
        hist_rd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_flags: got done=%b err=%b rd=%0d want 0",
               stat_done, stat_hist_err, hist_rd_data);
    end
    rst_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_basic;
    int lat, d0, nz;
    logic [31:0] d;
    logic [9:0] a;
    ramp = 1'b0;
    pconst = 8'h40;
    set_rect(0, 0, 8, 4);
    d0 = done_cnt;
    run_frame(8, 4, 1100, lat);
    cmp++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    cmp++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0);
    end
    cmp++;
    if (stat_pix_cnt !== 32'd32) begin
      bad++;
      $display("FAIL basic_cnt: got %0d want 32", stat_pix_cnt);
    end
    cmp++;
    if (stat_sum !== 32'd2048) begin
      bad++;
      $display("FAIL basic_sum: got %0d want 2048", stat_sum);
    end
    cmp++;
    if (stat_hist_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_err: got %b want 0", stat_hist_err);
    end
    for (int c = 0; c < 4; c++) begin
      a = {2'(c), 8'h40};
      hrd(a, d);
      cmp++;
      if (d !== 32'd8) begin
        bad++;
        $display("FAIL basic_bin_ch%0d: got %0d want 8", c, d);
      end
    end
    nz = 0;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      hrd(a, d);
      if (a[7:0] != 8'h40 && d !== 32'd0) nz++;
    end
    cmp++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL basic_other_bins: got %0d nonzero want 0", nz);
    end
  endtask

  task automatic test_window;
    int lat;
    logic [31:0] d;
    ramp = 1'b1;
    set_rect(2, 1, 4, 2);
    run_frame(8, 4, 1100, lat);
    cmp++;
    if (stat_pix_cnt !== 32'd8 || stat_sum !== 32'd28) begin
      bad++;
      $display("FAIL window_cnt_sum: got %0d/%0d want 8/28",
               stat_pix_cnt, stat_sum);
    end
    cmp++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL window_latency: got %0d want 4", lat);
    end
    hrd({2'd2, 8'd2}, d);
    cmp++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL window_gb_bin2: got %0d want 1", d);
    end
    hrd({2'd1, 8'd3}, d);
    cmp++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL window_gr_bin3: got %0d want 1", d);
    end
    hrd({2'd3, 8'd5}, d);
    cmp++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL window_b_bin5: got %0d want 1", d);
    end
    hrd({2'd0, 8'd3}, d);
    cmp++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL window_r_bin3: got %0d want 0", d);
    end
    hrd({2'd0, 8'd1}, d);
    cmp++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL window_outside_x1: got %0d want 0", d);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] d;
    ramp = 1'b0;
    pconst = 8'hFF;
    set_rect(0, 0, 32, 1);
    run_frame(32, 1, 1100, lat);
    cmp++;
    if (stat_pix_cnt !== 32'd32 || stat_sum !== 32'd8160) begin
      bad++;
      $display("FAIL b2b_cnt_sum: got %0d/%0d want 32/8160",
               stat_pix_cnt, stat_sum);
    end
    hrd({2'd0, 8'hFF}, d);
    cmp++;
    if (d !== 32'd16) begin
      bad++;
      $display("FAIL b2b_r_binff: got %0d want 16", d);
    end
    hrd({2'd1, 8'hFF}, d);
    cmp++;
    if (d !== 32'd16) begin
      bad++;
      $display("FAIL b2b_gr_binff: got %0d want 16", d);
    end
  endtask

  task automatic test_clear_overlap;
    int lat;
    logic [31:0] d;
    ramp = 1'b0;
    pconst = 8'h10;
    set_rect(0, 0, 8, 4);
    run_frame(8, 4, 10, lat);
    cmp++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL overlap_latency: got %0d want 4", lat);
    end
    cmp++;
    if (stat_pix_cnt !== 32'd32 || stat_sum !== 32'd512) begin
      bad++;
      $display("FAIL overlap_cnt_sum: got %0d/%0d want 32/512",
               stat_pix_cnt, stat_sum);
    end
    cmp++;
    if (stat_hist_err !== 1'b1) begin
      bad++;
      $display("FAIL overlap_err: got %b want 1", stat_hist_err);
    end
    hrd({2'd0, 8'h10}, d);
    cmp++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL overlap_r_bin10: got %0d want 0", d);
    end
  endtask

  task automatic test_disable_empty;
    int lat, d0;
    ramp = 1'b0;
    pconst = 8'h40;
    set_rect(0, 0, 8, 4);
    stat_en = 1'b0;
    d0 = done_cnt;
    run_frame(8, 4, 40, lat);
    stat_en = 1'b1;
    cmp++;
    if (lat !== -1 || done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL disabled_done: got lat=%0d pulses=%0d want -1/0",
               lat, done_cnt - d0);
    end
    cmp++;
    if (stat_pix_cnt !== 32'd32 || stat_sum !== 32'd512 ||
        stat_hist_err !== 1'b1) begin
      bad++;
      $display("FAIL disabled_hold: got %0d/%0d/%b want 32/512/1",
               stat_pix_cnt, stat_sum, stat_hist_err);
    end
    set_rect(0, 0, 0, 4);
    run_frame(8, 4, 1100, lat);
    cmp++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL empty_latency: got %0d want 4", lat);
    end
    cmp++;
    if (stat_pix_cnt !== 32'd0 || stat_sum !== 32'd0 ||
        stat_hist_err !== 1'b0) begin
      bad++;
      $display("FAIL empty_results: got %0d/%0d/%b want 0/0/0",
               stat_pix_cnt, stat_sum, stat_hist_err);
    end
  endtask

  task automatic test_mid_reset;
    int lat, d0;
    ramp = 1'b0;
    pconst = 8'h40;
    set_rect(0, 0, 8, 4);
    run_frame(8, 4, 1100, lat);
    cmp++;
    if (stat_pix_cnt !== 32'd32) begin
      bad++;
      $display("FAIL midrst_pre_cnt: got %0d want 32", stat_pix_cnt);
    end
    in_vsync = 1'b1;
    repeat (1100) tick;
    lines(8, 2);
    rst_n = 1'b0;
    #1;
    cmp++;
    if (stat_pix_cnt !== 32'd0 || stat_sum !== 32'd0 ||
        stat_hist_err !== 1'b0 || stat_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: got %0d/%0d/%b/%b want 0",
               stat_pix_cnt, stat_sum, stat_hist_err, stat_done);
    end
    repeat (2) tick;
    rst_n = 1'b1;
    d0 = done_cnt;
    lines(8, 2);
    end_frame(lat);
    cmp++;
    if (lat !== -1 || done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL midrst_skipped: got lat=%0d pulses=%0d want -1/0",
               lat, done_cnt - d0);
    end
    run_frame(8, 4, 1100, lat);
    cmp++;
    if (lat !== 4 || stat_pix_cnt !== 32'd32 || stat_sum !== 32'd2048) begin
      bad++;
      $display("FAIL midrst_next: got lat=%0d %0d/%0d want 4 32/2048",
               lat, stat_pix_cnt, stat_sum);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_window;
    test_back_to_back;
    test_clear_overlap;
    test_disable_empty;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
